// File: rtl/set_assoc_lookup_fill.sv
// N-way set-associative lookup/fill engine with true-LRU replacement.
// Tag, valid, data and age arrays live in registers. Hit/miss counters saturate.
module set_assoc_lookup_fill #(
  parameter int WAYS        = 4,
  parameter int SETS        = 16,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [BLOCK_BYTES*8-1:0] req_block,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_hit,
  output logic [$clog2(WAYS)-1:0]  rsp_way,
  output logic [BLOCK_BYTES*8-1:0] rsp_data,
  output logic                     rsp_evict,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int BLK_W = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_RESP} state_t;
  state_t r_state, w_next;

  logic [SETS-1:0][WAYS-1:0]            r_vld;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] r_tag;
  logic [SETS-1:0][WAYS-1:0][BLK_W-1:0] r_data;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] r_age;

  logic [TAG_W-1:0] r_req_tag;
  logic [IDX_W-1:0] r_req_idx;
  logic [BLK_W-1:0] r_req_blk;

  logic [WAYS-1:0]            r_rd_vld;
  logic [WAYS-1:0][TAG_W-1:0] r_rd_tag;
  logic [WAYS-1:0][BLK_W-1:0] r_rd_data;
  logic [WAYS-1:0][WAY_W-1:0] r_rd_age;

  logic                       r_rsp_valid, r_rsp_hit, r_rsp_evict;
  logic [WAY_W-1:0]           r_rsp_way;
  logic [BLK_W-1:0]           r_rsp_data;
  logic [CNT_W-1:0]           r_hit_cnt, r_miss_cnt;

  logic [WAYS-1:0]            w_hit_vec;
  logic                       w_hit, w_all_vld;
  logic [WAY_W-1:0]           w_hit_way, w_lru_way, w_inv_way, w_vic_way, w_way, w_old_age;
  logic [WAYS-1:0][WAY_W-1:0] w_new_age;
  logic                       w_accept;

  generate
    if (OFF_W > 0) begin : g_off
      logic w_unused_off;
      assign w_unused_off = ^req_addr[OFF_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_READ;
      end
      S_READ: w_next = S_CMP;
      S_CMP:  w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_req_tag <= req_addr[ADDR_W-1 -: TAG_W];
      r_req_idx <= req_addr[OFF_W +: IDX_W];
      r_req_blk <= req_block;
    end
  end

  // Snapshot the whole set one cycle before compare, like a synchronous array read.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_READ) begin
      r_rd_vld  <= r_vld[r_req_idx];
      r_rd_tag  <= r_tag[r_req_idx];
      r_rd_data <= r_data[r_req_idx];
      r_rd_age  <= r_age[r_req_idx];
    end
  end

  always_comb begin
    w_hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      w_hit_vec[w] = r_rd_vld[w] && (r_rd_tag[w] == r_req_tag);
  end

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      if (!r_rd_vld[w]) w_inv_way = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++)
      if (r_rd_age[w] == WAY_W'(WAYS-1)) w_lru_way = WAY_W'(w);
    w_hit     = |w_hit_vec;
    w_all_vld = &r_rd_vld;
    w_vic_way = w_all_vld ? w_lru_way : w_inv_way;
    w_way     = w_hit ? w_hit_way : w_vic_way;
    w_old_age = r_rd_age[w_way];
    // Touched way becomes youngest; only ways younger than it age by one.
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == w_way)          w_new_age[w] = '0;
      else if (r_rd_age[w] < w_old_age) w_new_age[w] = r_rd_age[w] + WAY_W'(1);
      else                              w_new_age[w] = r_rd_age[w];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= WAY_W'(w);
    end else if (r_state == S_CMP) begin
      r_age[r_req_idx] <= w_new_age;
      if (!w_hit) r_vld[r_req_idx][w_vic_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == S_CMP && !w_hit) begin
      r_tag[r_req_idx][w_vic_way]  <= r_req_tag;
      r_data[r_req_idx][w_vic_way] <= r_req_blk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_data  <= '0;
      r_rsp_evict <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else if (r_state == S_CMP) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= w_hit;
      r_rsp_way   <= w_way;
      r_rsp_data  <= w_hit ? r_rd_data[w_hit_way] : r_req_blk;
      r_rsp_evict <= !w_hit && w_all_vld;
      if (w_hit  && r_hit_cnt  != '1) r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (!w_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end else if (r_state == S_RESP && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_way    = r_rsp_way;
  assign rsp_data   = r_rsp_data;
  assign rsp_evict  = r_rsp_evict;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
endmodule

// File: tb/tb_set_assoc_lookup_fill.sv
// Directed bench for set_assoc_lookup_fill: MRU-ordered list reference model feeds
// an expected-response queue that is drained as responses appear.
module tb_set_assoc_lookup_fill;
  localparam int WAYS = 4, SETS = 16, BB = 4, AW = 32, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_block, rsp_data;
  logic          rsp_hit, rsp_evict;
  logic [1:0]    rsp_way;
  logic [CW-1:0] hit_count, miss_count;

  set_assoc_lookup_fill #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_block(req_block), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_data(rsp_data), .rsp_evict(rsp_evict),
    .hit_count(hit_count), .miss_count(miss_count));

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    int          way;
    logic [31:0] data;
    bit          evict;
    int          hc;
    int          mc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  bit          mvld[SETS][WAYS];
  logic [25:0] mtag[SETS][WAYS];
  logic [31:0] mdat[SETS][WAYS];
  int          ord[SETS][WAYS];   // ord[s][0] is most recently used
  int          mh, mm;

  logic        o_hit, o_evict;
  logic [1:0]  o_way;
  logic [31:0] o_data;
  logic [CW-1:0] o_hc, o_mc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mvld[s][w] = 1'b0;
        ord[s][w]  = w;
      end
    mh = 0;
    mm = 0;
  endfunction

  function automatic void touch(input int s, input int a);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (ord[s][i] == a) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = a;
  endfunction

  function automatic void model_push(input logic [31:0] a, input logic [31:0] b);
    int          s = int'(a[5:2]);
    logic [25:0] t = a[31:6];
    int          hw = -1, vic = -1;
    exp_t        e;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && mvld[s][w] && mtag[s][w] == t) hw = w;
    if (hw >= 0) begin
      e.hit = 1'b1; e.way = hw; e.data = mdat[s][hw]; e.evict = 1'b0;
      mh = (mh < CMAX) ? mh + 1 : CMAX;
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (vic < 0 && !mvld[s][w]) vic = w;
      e.evict = (vic < 0);
      if (vic < 0) vic = ord[s][WAYS-1];
      mvld[s][vic] = 1'b1; mtag[s][vic] = t; mdat[s][vic] = b;
      e.hit = 1'b0; e.way = vic; e.data = b;
      mm = (mm < CMAX) ? mm + 1 : CMAX;
    end
    touch(s, e.way);
    e.hc = mh;
    e.mc = mm;
    sb.push_back(e);
  endfunction

  // Called #1 after a clock edge with the engine idle; returns the same way.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input int hold);
    int   lat;
    exp_t e;
    req_addr = a; req_block = b; req_valid = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    model_push(a, b);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;  // accept edge counts as the first
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    e = sb.pop_front();
    o_hit = rsp_hit; o_way = rsp_way; o_data = rsp_data; o_evict = rsp_evict;
    o_hc = hit_count; o_mc = miss_count;
    chk("rsp_hit", rsp_hit, e.hit);
    chk("rsp_way", rsp_way, e.way);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_evict", rsp_evict, e.evict);
    chk("hit_count", hit_count, e.hc);
    chk("miss_count", miss_count, e.mc);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid = 1'b1; req_addr = 32'h0000_0F80; req_block = 32'h5555_AAAA;
      end
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ready", req_ready, 0);
      chk("hold_data", rsp_data, e.data);
      chk("hold_way", rsp_way, e.way);
      chk("hold_hit", rsp_hit, e.hit);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_hit"}, rsp_hit, 0);
    chk({tag, "_rsp_way"}, rsp_way, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_evict"}, rsp_evict, 0);
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_miss_count"}, miss_count, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_block = '0; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("reset");

    // 1: cold miss fills way 0
    do_req(32'h0000_0040, 32'hDEAD_BEEF, 0);
    chk("t1_hit", o_hit, 0);
    chk("t1_way", o_way, 0);
    chk("t1_evict", o_evict, 0);
    chk("t1_miss_count", o_mc, 1);

    // 2: repeat hits with stored data, not the new block
    do_req(32'h0000_0040, 32'h1111_1111, 0);
    chk("t2_hit", o_hit, 1);
    chk("t2_way", o_way, 0);
    chk("t2_data", o_data, 32'hDEAD_BEEF);
    chk("t2_hit_count", o_hc, 1);

    // 3: fill set 0, fifth tag evicts LRU way 0, first tag then misses
    do_req(32'h0000_0080, 32'hA000_0002, 0);
    do_req(32'h0000_00C0, 32'hA000_0003, 0);
    do_req(32'h0000_0100, 32'hA000_0004, 0);
    chk("t3_fill_way3", o_way, 3);
    do_req(32'h0000_0140, 32'hA000_0005, 0);
    chk("t3_vic_way", o_way, 0);
    chk("t3_vic_evict", o_evict, 1);
    do_req(32'h0000_0040, 32'hA000_0001, 0);
    chk("t3_refetch_hit", o_hit, 0);

    // 4: touching way 0 makes way 1 the victim
    do_reset();
    for (int t = 1; t <= 4; t++)
      do_req((32'(t) << 6) | 32'h4, 32'hB000_0000 | 32'(t), 0);
    do_req(32'h0000_0044, 32'h0, 0);
    chk("t4_touch_hit", o_hit, 1);
    chk("t4_touch_way", o_way, 0);
    do_req(32'h0000_0144, 32'hB000_0005, 0);
    chk("t4_vic_way", o_way, 1);
    chk("t4_vic_evict", o_evict, 1);

    // 5: backpressure hold, then reset while in compare
    do_req(32'h0000_0044, 32'h0, 10);
    chk("t5_hold_hit", o_hit, 1);
    req_addr = 32'h0000_00C4; req_block = 32'hC0C0_C0C0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk_reset_outputs("cmp_reset");
    do_req(32'h0000_00C4, 32'hC1C1_C1C1, 0);
    chk("t5_post_hit", o_hit, 0);
    chk("t5_post_way", o_way, 0);
    chk("t5_post_evict", o_evict, 0);

    // 6: hit counter saturates at 15
    do_reset();
    do_req(32'h0000_0040, 32'h0BAD_F00D, 0);
    for (int i = 0; i < 20; i++) do_req(32'h0000_0040, 32'h0, 0);
    chk("t6_hit_sat", o_hc, 15);
    chk("t6_miss", o_mc, 1);
    chk("t6_data", o_data, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
